// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin scalar write arbiter: FSM state
// encoding, the widest requester count supported, and the rotate-and-encode
// helper used to pick the next owner.
package arb_pkg;

  localparam int ARB_N_REQ_MAX = 8;
  localparam int ARB_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request bit at or after ptr, wrapping explicitly modulo n so
  // that non-power-of-two requester counts rotate correctly.
  function automatic rr_pick_t rr_pick(input logic [ARB_N_REQ_MAX-1:0] req,
                                       input logic [ARB_IDX_W-1:0]     ptr,
                                       input int                       n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = 0; i < ARB_N_REQ_MAX; i++) begin
      j = (int'(ptr) + i) % n;
      if ((i < n) && !r.found && req[3'(j)]) begin
        r.found = 1'b1;
        r.idx   = ARB_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotates the request vector to start at
// the priority pointer and returns the first requester found.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [ARB_N_REQ_MAX-1:0] req_ext;
  rr_pick_t                 pick;

  // Widen to the package width, then rotate-and-encode from ptr.
  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
    pick               = rr_pick(req_ext, ARB_IDX_W'(ptr), N_REQ);
    idx                = IDX_W'(pick.idx);
    found              = pick.found;
  end

endmodule

// File: rtl/rr_scalar_write_arbiter.sv
// Round-robin arbiter that lets one requester at a time own a shared
// registered output bit. Ownership ends on request drop, release strobe or
// hold-limit expiry, followed by a one-cycle gap before re-arbitration.
module rr_scalar_write_arbiter
  import arb_pkg::*;
#(
  parameter int   N_REQ    = 3,
  parameter int   HOLD_MAX = 4,
  parameter logic Q_RST    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_srst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_last,
  input  logic [N_REQ-1:0] i_data,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_busy,
  output logic             o_q,
  output logic             o_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_MAX + 1);

  arb_state_t       state, state_n;
  logic [IW-1:0]    owner, owner_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic             busy, busy_n;
  logic             q, q_n;
  logic             timeout, timeout_n;
  logic             end_drop, end_last, end_hold, end_any;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IW)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign end_drop = ~i_req[owner];
  assign end_last = i_last[owner];
  assign end_hold = (cnt == CW'(HOLD_MAX));
  assign end_any  = end_drop | end_last | end_hold;

  // Next-state and next-output logic; a synchronous clear behaves like reset.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt;
    busy_n    = busy;
    q_n       = q;
    timeout_n = 1'b0;
    if (i_srst) begin
      state_n = IDLE;
      owner_n = '0;
      ptr_n   = '0;
      cnt_n   = '0;
      gnt_n   = '0;
      busy_n  = 1'b0;
      q_n     = Q_RST;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state_n = GRANT;
            owner_n = pick_idx;
            gnt_n   = N_REQ'(1) << pick_idx;
            busy_n  = 1'b1;
            cnt_n   = CW'(1);
            ptr_n   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
          end
        end
        GRANT: begin
          if (!end_drop) begin
            q_n = i_data[owner];
          end
          if (end_any) begin
            state_n   = GAP;
            gnt_n     = '0;
            busy_n    = 1'b0;
            cnt_n     = '0;
            timeout_n = end_hold & ~end_drop & ~end_last;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GAP: begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      q       <= Q_RST;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      q       <= q_n;
      timeout <= timeout_n;
    end
  end

  assign o_gnt     = gnt;
  assign o_busy    = busy;
  assign o_q       = q;
  assign o_timeout = timeout;

  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_arst) $onehot0(gnt));

endmodule

// File: tb/tb_rr_scalar_write_arbiter.sv
// Directed bench for the round-robin scalar write arbiter (3 requesters,
// hold limit 4, idle output 0).
module tb_rr_scalar_write_arbiter;

  logic       clk;
  logic       arst;
  logic       srst;
  logic [2:0] req;
  logic [2:0] last;
  logic [2:0] data;
  logic [2:0] gnt;
  logic       busy;
  logic       q;
  logic       timeout;

  int errors;
  int checks;

  logic [2:0] exp_seq [4];

  rr_scalar_write_arbiter #(
    .N_REQ    (3),
    .HOLD_MAX (4),
    .Q_RST    (1'b0)
  ) dut (
    .i_clk     (clk),
    .i_arst    (arst),
    .i_srst    (srst),
    .i_req     (req),
    .i_last    (last),
    .i_data    (data),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_q       (q),
    .o_timeout (timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] l, input logic [2:0] d);
    req  = r;
    last = l;
    data = d;
  endtask

  task automatic check_output(input string tag, input logic [2:0] eg, input logic eb,
                              input logic eq, input logic et);
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, eb);
    end
    checks++;
    assert (q === eq) else begin
      errors++;
      $error("[TB] FAIL %s q observed=%b expected=%b", tag, q, eq);
    end
    checks++;
    assert (timeout === et) else begin
      errors++;
      $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, timeout, et);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    errors = 0;
    checks = 0;
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001;
    arst = 1'b1;
    srst = 1'b0;
    apply_stimulus(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    check_output("reset", 3'b000, 1'b0, 1'b0, 1'b0);

    // First grant and first data capture one edge later.
    arst = 1'b0;
    apply_stimulus(3'b111, 3'b000, 3'b111);
    tick();
    check_output("first_grant", 3'b001, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("first_capture", 3'b001, 1'b1, 1'b1, 1'b0);

    // Async reset mid-cycle with all requests held.
    #3 arst = 1'b1;
    #1 check_output("async_reset", 3'b000, 1'b0, 1'b0, 1'b0);
    #1 arst = 1'b0;
    tick();
    check_output("post_reset_grant", 3'b001, 1'b1, 1'b0, 1'b0);

    // Round robin: each owner releases on its second granted cycle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rr_hold", exp_seq[i], 1'b1, 1'b1, 1'b0);
      last = exp_seq[i];
      tick();
      check_output("rr_release", 3'b000, 1'b0, 1'b1, 1'b0);
      last = 3'b000;
      tick();
      check_output("rr_gap", 3'b000, 1'b0, 1'b1, 1'b0);
      tick();
      check_output("rr_next", exp_seq[i+1], 1'b1, 1'b1, 1'b0);
    end

    // Owner 0 drops its request: no capture on that edge.
    apply_stimulus(3'b010, 3'b000, 3'b000);
    tick();
    check_output("drop_no_capture", 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("drop_gap", 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("owner1_grant", 3'b010, 1'b1, 1'b1, 1'b0);

    // Data path: owner 1 drives 1,0,1 then releases.
    data = 3'b010;
    tick();
    check_output("data_1", 3'b010, 1'b1, 1'b1, 1'b0);
    data = 3'b000;
    tick();
    check_output("data_0", 3'b010, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'b010, 3'b010, 3'b010);
    tick();
    check_output("data_last_capture", 3'b000, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'b000, 3'b000, 3'b000);
    tick();
    check_output("q_hold_gap", 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("q_hold_idle", 3'b000, 1'b0, 1'b1, 1'b0);

    // Timeout: owner 0 holds its request for HOLD_MAX cycles (ptr wraps 2->0).
    apply_stimulus(3'b001, 3'b000, 3'b001);
    tick();
    check_output("to_grant", 3'b001, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("to_cnt2", 3'b001, 1'b1, 1'b1, 1'b0);
    data = 3'b000;
    tick();
    check_output("to_cnt3", 3'b001, 1'b1, 1'b0, 1'b0);
    data = 3'b001;
    tick();
    check_output("to_cnt4", 3'b001, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("timeout_pulse", 3'b000, 1'b0, 1'b1, 1'b1);
    tick();
    check_output("timeout_gap", 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("timeout_regrant", 3'b001, 1'b1, 1'b1, 1'b0);

    // Release strobe coinciding with hold expiry: no timeout pulse.
    tick();
    tick();
    tick();
    check_output("simul_cnt4", 3'b001, 1'b1, 1'b1, 1'b0);
    last = 3'b001;
    tick();
    check_output("simul_end", 3'b000, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'b100, 3'b000, 3'b100);
    tick();
    check_output("simul_gap", 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("owner2_grant", 3'b100, 1'b1, 1'b1, 1'b0);

    // Sync clear during owner 2's grant.
    tick();
    check_output("owner2_data", 3'b100, 1'b1, 1'b1, 1'b0);
    srst = 1'b1;
    tick();
    check_output("srst_clear", 3'b000, 1'b0, 1'b0, 1'b0);
    srst = 1'b0;
    req  = 3'b101;
    tick();
    check_output("srst_regrant", 3'b001, 1'b1, 1'b0, 1'b0);

    // Sync clear during owner 1 must also return the pointer to 0.
    apply_stimulus(3'b010, 3'b000, 3'b010);
    tick();
    check_output("drop_owner0", 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_output("owner1_again", 3'b010, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("owner1_data", 3'b010, 1'b1, 1'b1, 1'b0);
    srst = 1'b1;
    req  = 3'b101;
    tick();
    check_output("srst_clear2", 3'b000, 1'b0, 1'b0, 1'b0);
    srst = 1'b0;
    tick();
    check_output("srst_ptr_reset", 3'b001, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_scalar_write_arbiter.md
Name: rr_scalar_write_arbiter

Overview:
- Round-robin arbiter that shares one registered scalar output among N_REQ requester modules.
- Each requester asserts a request and supplies a data bit. The winner owns the output register until it releases, drops its request, or times out.
- Sits between several sub-module instances and one interface output member, so only one always_ff source ever drives that member.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- HOLD_MAX, 4, maximum consecutive granted cycles per ownership (1..15).
- Q_RST, 1'b0, reset and idle value of o_q.

Ports:
- i_clk  input  1  clock, rising edge.
- i_arst  input  1  asynchronous reset, active-high.
- i_srst  input  1  synchronous clear, active-high. Same effect as i_arst, taken at the clock edge.
- i_req  input  N_REQ  per-requester request level.
- i_last  input  N_REQ  per-requester release strobe. Sampled only for the current owner.
- i_data  input  N_REQ  per-requester data bit.
- o_gnt  output  N_REQ  one-hot grant, registered.
- o_busy  output  1  high while in GRANT.
- o_q  output  1  shared registered output.
- o_timeout  output  1  one-cycle pulse when an ownership ends by HOLD_MAX expiry.

Behaviour:
- Reset (i_arst async, or i_srst sync):
  - o_gnt=0, o_busy=0, o_q=Q_RST, o_timeout=0.
  - State IDLE, priority pointer ptr=0, hold counter cnt=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any i_req bit is set, pick the first set bit searching from index ptr upward, wrapping modulo N_REQ.
  - Next edge: owner=winner, o_gnt=1<<winner, o_busy=1, cnt=1, state GRANT, ptr=(winner+1) mod N_REQ.
  - If no request: hold state; o_q keeps its value.
- GRANT, every edge:
  - o_q <= i_data[owner].
  - Ownership ends when any of the following hold:
    - (a) i_req[owner]==0;
    - (b) i_last[owner]==1;
    - (c) cnt==HOLD_MAX.
  - On end: o_gnt=0, o_busy=0, cnt=0, state GAP. o_timeout=1 only if (c) holds and neither (a) nor (b) does.
  - Otherwise: cnt=cnt+1.
  - The edge that ends ownership still captures i_data[owner] into o_q when (b) or (c) ends it. It does not capture when (a) ends it.
- GAP: exactly one cycle with no grant. o_timeout returns to 0. Next state is IDLE.
- Latency:
  - Request seen at edge k gives o_gnt at edge k+1 and the first o_q update at edge k+2.
  - Minimum turnaround between two owners is 2 idle edges (GAP, then IDLE arbitration).
- Fairness: after owning, a requester has lowest priority at the next arbitration. No requester waits more than N_REQ-1 ownerships.
- Simultaneous events:
  - If (a), (b) and (c) occur on the same edge, the end is a single event and o_timeout=0.
  - Requests from non-owners during GRANT are ignored; they are not latched.
- Reset mid-GRANT: o_gnt clears immediately (async), o_q goes to Q_RST, ptr returns to 0.
- Width rules:
  - cnt is $clog2(HOLD_MAX+1) bits and never exceeds HOLD_MAX.
  - ptr and owner are $clog2(N_REQ) bits; wrap is explicit modulo N_REQ, including non-power-of-2 N_REQ.
- o_gnt is always zero or one-hot. An assertion checks this.

Decomposition:
- Shared package arb_pkg:
  - enum arb_state_t {IDLE, GRANT, GAP};
  - function rr_pick(req, ptr) returning index and a found flag;
  - constant ARB_N_REQ_MAX=8.
- One sub-module, rr_priority_pick: combinational rotate-and-priority-encode, N_REQ-parameterised. Used only by IDLE arbitration.

Test Plan:
- Reset/idle: assert i_arst mid-cycle with i_req=3'b111 held → o_gnt=000 immediately, o_q=0; after release, o_gnt=001 one edge later.
- Round-robin: i_req=3'b111 held with i_last pulsed on each owner's 2nd granted cycle → grant sequence 001,010,100,001, each held 2 edges with a GAP between.
- Timeout: i_req=3'b001 held, i_last=0, HOLD_MAX=4 → o_gnt=001 for 4 edges, o_timeout pulse on the 4th ending edge, GAP, then re-grant 001.
- Data path: owner 1 with i_data=2'b1x pattern 1,0,1 over granted cycles → o_q follows 1,0,1 one edge later; after release, o_q holds the last value.
- Simultaneous end: at cnt==HOLD_MAX assert i_last[owner]=1 → ownership ends, o_timeout stays 0.
- Sync clear: pulse i_srst for one edge during GRANT with owner=2 → next edge o_gnt=000, o_q=Q_RST, ptr=0, so with i_req=3'b101 the next grant is 001.
